// File: rtl/arp_rx_filter_pkg.sv
// Shared constants, state encoding and byte-level helpers for the ARP receive filter.
// Byte offsets are counted from the first destination-MAC byte of the frame.
package arp_rx_filter_pkg;

  localparam logic [47:0] BRDCAST_DEST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam logic [15:0] ARP_FRAME_TYPE    = 16'h0806;
  localparam logic [15:0] ETH_HW_TYPE       = 16'h0001;
  localparam logic [15:0] IP_PROT_TYPE      = 16'h0800;
  localparam logic [7:0]  ETH_HW_LEN        = 8'd6;
  localparam logic [7:0]  IP_PROT_LEN       = 8'd4;
  localparam logic [15:0] REQ_ARP_OP        = 16'h0001;
  localparam logic [15:0] RPL_ARP_OP        = 16'h0002;
  localparam int          ARP_MIN_LEN       = 42;

  localparam logic [5:0] IDX_SHA      = 6'd22;
  localparam logic [5:0] IDX_SPA      = 6'd28;
  localparam logic [5:0] IDX_TPA      = 6'd38;
  localparam logic [5:0] LAST_HDR_IDX = 6'(ARP_MIN_LEN - 1);
  localparam logic [5:0] CNT_MAX      = 6'd63;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RX   = 1'b1
  } rx_state_e;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte idx (0 = most significant) of a 48-bit address.
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * idx);
    return sh[47:40];
  endfunction

  // Fixed-header bytes 12..21; every other offset is unconstrained here.
  function automatic logic hdr_byte_bad(input logic [5:0] idx, input logic [7:0] b,
                                        input logic accept_reply);
    logic bad;
    bad = 1'b0;
    case (idx)
      6'd12:   bad = (b != ARP_FRAME_TYPE[15:8]);
      6'd13:   bad = (b != ARP_FRAME_TYPE[7:0]);
      6'd14:   bad = (b != ETH_HW_TYPE[15:8]);
      6'd15:   bad = (b != ETH_HW_TYPE[7:0]);
      6'd16:   bad = (b != IP_PROT_TYPE[15:8]);
      6'd17:   bad = (b != IP_PROT_TYPE[7:0]);
      6'd18:   bad = (b != ETH_HW_LEN);
      6'd19:   bad = (b != IP_PROT_LEN);
      6'd20:   bad = (b != REQ_ARP_OP[15:8]);
      6'd21:   bad = !((b == REQ_ARP_OP[7:0]) || (accept_reply && (b == RPL_ARP_OP[7:0])));
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/arp_rx_filter_if.sv
// Byte-stream input and decoded-result output of the ARP filter.
// slave = filter side, master = MAC/consumer side.
interface arp_rx_filter_if
  import arp_rx_filter_pkg::*;
#(
  parameter int NUM_IP = 2
) ();
  localparam int IDX_W = idx_width(NUM_IP);

  logic             data_valid;
  logic [7:0]       data_rx;
  logic             data_last;
  logic             arp_valid;
  logic             arp_ready;
  logic             arp_is_reply;
  logic [IDX_W-1:0] arp_ip_idx;
  logic [47:0]      source_mac;
  logic [31:0]      source_ip;

  modport master (
    output data_valid, data_rx, data_last, arp_ready,
    input  arp_valid, arp_is_reply, arp_ip_idx, source_mac, source_ip
  );

  modport slave (
    input  data_valid, data_rx, data_last, arp_ready,
    output arp_valid, arp_is_reply, arp_ip_idx, source_mac, source_ip
  );
endinterface

// File: rtl/arp_ip_match.sv
// Per-entry target-IP comparators over bytes 38..41 with a lowest-index priority encoder.
// Match outputs reflect the current beat, so the frame can be judged on its last byte.
module arp_ip_match
  import arp_rx_filter_pkg::*;
#(
  parameter int NUM_IP = 2,
  parameter int IDX_W  = 1
) (
  input  logic                clk,
  input  logic                areset_n,
  input  logic [32*NUM_IP-1:0] my_ip_i,
  input  logic                beat_i,
  input  logic                first_i,
  input  logic [5:0]          byte_idx_i,
  input  logic [7:0]          data_i,
  output logic                match_any_o,
  output logic [IDX_W-1:0]    match_idx_o
);
  logic [NUM_IP-1:0] hit_q, hit_d;
  logic [5:0]        rel;
  logic              in_tpa;

  assign rel    = byte_idx_i - IDX_TPA;
  assign in_tpa = beat_i && (byte_idx_i >= IDX_TPA) && (byte_idx_i <= IDX_TPA + 6'd3);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_IP; gi++) begin : g_cmp
      logic [31:0] ip_sh;
      assign ip_sh    = my_ip_i[32*gi +: 32] << (8 * rel[1:0]);
      assign hit_d[gi] = (first_i | hit_q[gi]) & ~(in_tpa & (data_i != ip_sh[31:24]));
    end
  endgenerate

  always_comb begin
    match_idx_o = '0;
    for (int k = NUM_IP - 1; k >= 0; k--) begin
      if (hit_d[k]) match_idx_o = IDX_W'(k);
    end
  end

  assign match_any_o = |hit_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) hit_q <= '1;
    else           hit_q <= hit_d;
  end
endmodule

// File: rtl/arp_rx_filter.sv
// Streaming ARP receive filter: validates header bytes on the fly, captures sender fields,
// and hands one decoded result per good frame to a 1-deep valid/ready slot.
module arp_rx_filter
  import arp_rx_filter_pkg::*;
#(
  parameter int NUM_IP       = 2,
  parameter int ACCEPT_REPLY = 1,
  parameter int CNT_W        = 16
) (
  input  logic                 clk,
  input  logic                 areset_n,
  input  logic [47:0]          my_mac,
  input  logic [32*NUM_IP-1:0] my_ip,
  arp_rx_filter_if.slave       bus,
  output logic [CNT_W-1:0]     drop_cnt
);
  localparam int IDX_W = idx_width(NUM_IP);

  rx_state_e        state_q, state_d;
  logic             first_beat, last_beat;
  logic [5:0]       cnt_q, cnt_d;
  logic             err_q, err_d, dest_bc_q, dest_bc_d, dest_me_q, dest_me_d;
  logic             reply_q, reply_d;
  logic [47:0]      sha_q, sha_d;
  logic [31:0]      spa_q, spa_d;
  logic             match_any, frame_good;
  logic [IDX_W-1:0] match_idx;
  logic             valid_q, valid_d, slot_reply_q, slot_reply_d;
  logic [IDX_W-1:0] slot_idx_q, slot_idx_d;
  logic [47:0]      slot_mac_q, slot_mac_d;
  logic [31:0]      slot_ip_q, slot_ip_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) state_q <= ST_IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.data_valid && !bus.data_last) state_d = ST_RX;
      ST_RX:   if (bus.data_valid && bus.data_last)  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    first_beat = bus.data_valid && (state_q == ST_IDLE);
    last_beat  = bus.data_valid && bus.data_last;
  end

  arp_ip_match #(.NUM_IP(NUM_IP), .IDX_W(IDX_W)) u_match (
    .clk         (clk),
    .areset_n    (areset_n),
    .my_ip_i     (my_ip),
    .beat_i      (bus.data_valid),
    .first_i     (first_beat),
    .byte_idx_i  (cnt_q),
    .data_i      (bus.data_rx),
    .match_any_o (match_any),
    .match_idx_o (match_idx)
  );

  // Per-frame flags restart on byte 0 so back-to-back frames need no idle cycle.
  always_comb begin
    cnt_d     = cnt_q;
    err_d     = err_q;
    dest_bc_d = dest_bc_q;
    dest_me_d = dest_me_q;
    reply_d   = reply_q;
    sha_d     = sha_q;
    spa_d     = spa_q;
    if (bus.data_valid) begin
      if (first_beat) begin
        err_d     = 1'b0;
        dest_bc_d = 1'b1;
        dest_me_d = 1'b1;
        reply_d   = 1'b0;
      end
      if (cnt_q < 6'd6) begin
        dest_bc_d = dest_bc_d && (bus.data_rx == mac_byte(BRDCAST_DEST_ADDR, cnt_q));
        dest_me_d = dest_me_d && (bus.data_rx == mac_byte(my_mac, cnt_q));
      end
      err_d = err_d | hdr_byte_bad(cnt_q, bus.data_rx, ACCEPT_REPLY != 0);
      if (cnt_q == 6'd21) reply_d = (bus.data_rx == RPL_ARP_OP[7:0]);
      if ((cnt_q >= IDX_SHA) && (cnt_q < IDX_SPA)) sha_d = {sha_q[39:0], bus.data_rx};
      if ((cnt_q >= IDX_SPA) && (cnt_q < IDX_SPA + 6'd4)) spa_d = {spa_q[23:0], bus.data_rx};
      if (bus.data_last)          cnt_d = '0;
      else if (cnt_q != CNT_MAX)  cnt_d = cnt_q + 6'd1;
    end
  end

  // A reply must be unicast to us; a request may also be broadcast.
  assign frame_good = !err_d && (cnt_q >= LAST_HDR_IDX) && match_any &&
                      (reply_d ? dest_me_d : (dest_bc_d || dest_me_d));

  always_comb begin
    valid_d      = valid_q;
    slot_reply_d = slot_reply_q;
    slot_idx_d   = slot_idx_q;
    slot_mac_d   = slot_mac_q;
    slot_ip_d    = slot_ip_q;
    drop_d       = drop_q;
    if (last_beat && frame_good) begin
      if (!valid_q || bus.arp_ready) begin
        valid_d      = 1'b1;
        slot_reply_d = reply_d;
        slot_idx_d   = match_idx;
        slot_mac_d   = sha_d;
        slot_ip_d    = spa_d;
      end else if (drop_q != '1) begin
        drop_d = drop_q + 1'b1;
      end
    end else if (valid_q && bus.arp_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q        <= '0;
      err_q        <= 1'b0;
      dest_bc_q    <= 1'b0;
      dest_me_q    <= 1'b0;
      reply_q      <= 1'b0;
      sha_q        <= '0;
      spa_q        <= '0;
      valid_q      <= 1'b0;
      slot_reply_q <= 1'b0;
      slot_idx_q   <= '0;
      slot_mac_q   <= '0;
      slot_ip_q    <= '0;
      drop_q       <= '0;
    end else begin
      cnt_q        <= cnt_d;
      err_q        <= err_d;
      dest_bc_q    <= dest_bc_d;
      dest_me_q    <= dest_me_d;
      reply_q      <= reply_d;
      sha_q        <= sha_d;
      spa_q        <= spa_d;
      valid_q      <= valid_d;
      slot_reply_q <= slot_reply_d;
      slot_idx_q   <= slot_idx_d;
      slot_mac_q   <= slot_mac_d;
      slot_ip_q    <= slot_ip_d;
      drop_q       <= drop_d;
    end
  end

  assign bus.arp_valid    = valid_q;
  assign bus.arp_is_reply = slot_reply_q;
  assign bus.arp_ip_idx   = slot_idx_q;
  assign bus.source_mac   = slot_mac_q;
  assign bus.source_ip    = slot_ip_q;
  assign drop_cnt         = drop_q;
endmodule
